// File: rtl/led_pattern_seq.sv
// rtl/led_pattern_seq.sv - LED pattern sequencer: prescaler, address sequencer, pattern RAM, PWM
//
// Ports:
//   clk         in   system clock, all state on rising edge
//   rst         in   synchronous active-high reset
//   mode        in   00 forward, 01 reverse, 10 ping-pong, 11 hold
//   pause       in   1 = drop address steps (prescaler keeps running)
//   brightness  in   global duty = brightness / 2^PWM_W
//   wr_en       in   pattern write strobe
//   wr_addr     in   pattern write address (ignored when >= DEPTH)
//   wr_data     in   pattern write data
//   led         out  registered, PWM-gated LED drive
//   addr_out    out  current pattern address
//   tick        out  one-cycle step strobe, every CLK_DIV cycles
module led_pattern_seq #(
   parameter int LED_W   = 4,
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int CLK_DIV = 25000000,
   parameter int PWM_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             pause,
   input  logic [PWM_W-1:0] brightness,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [LED_W-1:0] wr_data,
   output logic [LED_W-1:0] led,
   output logic [AW-1:0]    addr_out,
   output logic             tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] ADDR_PEN  = AW'(DEPTH - 2);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   logic [CW-1:0]    count_q, count_d;
   logic             tick_q, tick_d;
   logic [AW-1:0]    addr_q, addr_d;
   dir_t             dir_q, dir_d;
   logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [LED_W-1:0] pattern_q, pattern_d;
   logic [LED_W-1:0] led_q, led_d;
   logic [LED_W-1:0] ram_q [DEPTH];
   logic [LED_W-1:0] ram_d [DEPTH];

   always_comb begin
      // prescaler and step strobe
      count_d = (count_q == CNT_LAST) ? '0 : count_q + 1'b1;
      tick_d  = (count_q == CNT_LAST);

      // address sequencer; mode is sampled on the stepping edge only
      addr_d = addr_q;
      dir_d  = dir_q;
      if (tick_q && !pause) begin
         if (int'(addr_q) >= DEPTH) begin
            // recovery from an unreachable address in any stepping mode
            if (mode != 2'b11) addr_d = '0;
         end else begin
            case (mode)
               2'b00: addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
               2'b01: addr_d = (addr_q == '0) ? ADDR_LAST : addr_q - 1'b1;
               2'b10: begin
                  // endpoints turn around without repeating themselves
                  if (dir_q == DIR_UP) begin
                     if (addr_q == ADDR_LAST) begin
                        dir_d  = DIR_DOWN;
                        addr_d = ADDR_PEN;
                     end else begin
                        addr_d = addr_q + 1'b1;
                     end
                  end else begin
                     if (addr_q == '0) begin
                        dir_d  = DIR_UP;
                        addr_d = AW'(1);
                     end else begin
                        addr_d = addr_q - 1'b1;
                     end
                  end
               end
               default: addr_d = addr_q;
            endcase
         end
      end

      // pattern RAM
      for (int i = 0; i < DEPTH; i++) ram_d[i] = ram_q[i];
      if (wr_en && (int'(wr_addr) < DEPTH)) ram_d[wr_addr] = wr_data;

      // read pipeline: RAM -> pattern -> gated led (2-cycle lag from addr)
      pattern_d = (int'(addr_q) < DEPTH) ? ram_q[addr_q] : '0;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      led_d     = pattern_q & {LED_W{pwm_cnt_q < brightness}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         tick_q    <= 1'b0;
         addr_q    <= '0;
         dir_q     <= DIR_UP;
         pwm_cnt_q <= '0;
         pattern_q <= '0;
         led_q     <= '0;
         for (int i = 0; i < DEPTH; i++) ram_q[i] <= LED_W'(1) << (i % LED_W);
      end else begin
         count_q   <= count_d;
         tick_q    <= tick_d;
         addr_q    <= addr_d;
         dir_q     <= dir_d;
         pwm_cnt_q <= pwm_cnt_d;
         pattern_q <= pattern_d;
         led_q     <= led_d;
         for (int i = 0; i < DEPTH; i++) ram_q[i] <= ram_d[i];
      end
   end

   assign led      = led_q;
   assign addr_out = addr_q;
   assign tick     = tick_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb/tb_led_pattern_seq.sv - self-checking bench for led_pattern_seq
module tb_led_pattern_seq;

   localparam int LED_W   = 4;
   localparam int DEPTH   = 8;
   localparam int AW      = 4;
   localparam int CLK_DIV = 4;
   localparam int PWM_W   = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       mode = 2'b00;
   logic             pause = 1'b0;
   logic [PWM_W-1:0] brightness = '0;
   logic             wr_en = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [LED_W-1:0] wr_data = '0;
   logic [LED_W-1:0] led;
   logic [AW-1:0]    addr_out;
   logic             tick;

   led_pattern_seq #(
      .LED_W(LED_W), .DEPTH(DEPTH), .AW(AW), .CLK_DIV(CLK_DIV), .PWM_W(PWM_W)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .pause(pause), .brightness(brightness),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .led(led), .addr_out(addr_out), .tick(tick)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: edges since reset, address walk, RAM contents
   int       m_n;
   int       m_addr;
   bit       m_up;
   bit       m_tick;
   int       m_ram [DEPTH];
   int       m_pat;
   int       m_led;

   function automatic void model_edge(input bit r, input int md, input bit p, input int b,
                                      input bit we, input int wa, input int wd);
      if (r) begin
         m_n = 0; m_addr = 0; m_up = 1; m_tick = 0; m_pat = 0; m_led = 0;
         for (int i = 0; i < DEPTH; i++) m_ram[i] = 1 << (i % LED_W);
      end else begin
         bit stp;
         stp   = m_tick && !p;
         m_led = ((m_n % (1 << PWM_W)) < b) ? m_pat : 0;
         m_pat = m_ram[m_addr];
         if (we && wa < DEPTH) m_ram[wa] = wd;
         if (stp) begin
            case (md)
               0: m_addr = (m_addr + 1) % DEPTH;
               1: m_addr = (m_addr + DEPTH - 1) % DEPTH;
               2: begin
                  if (m_up && m_addr == DEPTH - 1) m_up = 0;
                  else if (!m_up && m_addr == 0) m_up = 1;
                  m_addr = m_up ? m_addr + 1 : m_addr - 1;
               end
               default: ;
            endcase
         end
         m_n++;
         m_tick = (m_n % CLK_DIV) == 0;
      end
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // one clock: drive inputs, advance model, compare all outputs
   task automatic step(input bit r, input int md, input bit p, input int b,
                       input bit we = 0, input int wa = 0, input int wd = 0);
      rst = r; mode = 2'(md); pause = p; brightness = PWM_W'(b);
      wr_en = we; wr_addr = AW'(wa); wr_data = LED_W'(wd);
      @(posedge clk);
      model_edge(r, md, p, b, we, wa, wd);
      #1;
      check("addr", int'(addr_out), m_addr);
      check("tick", int'(tick), int'(m_tick));
      check("led", int'(led), m_led);
   endtask

   typedef struct {
      bit rst;
      int mode;
      int bright;
      int e_addr;
      int e_tick;
      int e_led;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int cnt;
      int a0;
      int v;
      bit seen;

      // reset then forward walk at full brightness; last row drops brightness to 0
      tbl[0]  = '{1, 0, 15, 0, 0, 0};
      tbl[1]  = '{0, 0, 15, 0, 0, 0};
      tbl[2]  = '{0, 0, 15, 0, 0, 1};
      tbl[3]  = '{0, 0, 15, 0, 0, 1};
      tbl[4]  = '{0, 0, 15, 0, 1, 1};
      tbl[5]  = '{0, 0, 15, 1, 0, 1};
      tbl[6]  = '{0, 0, 15, 1, 0, 1};
      tbl[7]  = '{0, 0, 15, 1, 0, 2};
      tbl[8]  = '{0, 0, 15, 1, 1, 2};
      tbl[9]  = '{0, 0, 15, 2, 0, 2};
      tbl[10] = '{0, 0, 15, 2, 0, 2};
      tbl[11] = '{0, 0, 15, 2, 0, 4};
      tbl[12] = '{0, 0, 0,  2, 1, 0};
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].rst, tbl[i].mode, 0, tbl[i].bright);
         check($sformatf("tbl%0d_addr", i), int'(addr_out), tbl[i].e_addr);
         check($sformatf("tbl%0d_tick", i), int'(tick), tbl[i].e_tick);
         check($sformatf("tbl%0d_led", i), int'(led), tbl[i].e_led);
      end

      // pause at addr 3 for three ticks, then exactly one step
      cnt = 0;
      while (addr_out != 3 && cnt < 100) begin step(0, 0, 0, 15); cnt++; end
      check("reach_addr3", int'(addr_out), 3);
      for (int i = 0; i < 3 * CLK_DIV; i++) step(0, 0, 1, 15);
      check("pause_hold", int'(addr_out), 3);
      cnt = 0;
      while (addr_out == 3 && cnt < 50) begin step(0, 0, 0, 15); cnt++; end
      check("after_pause_addr", int'(addr_out), 4);
      check("after_pause_lat_ok", int'(cnt <= CLK_DIV), 1);
      for (int i = 0; i < CLK_DIV; i++) step(0, 0, 0, 15);
      check("no_catchup", int'(addr_out), 5);

      // hold mode: address frozen, tick keeps pulsing
      a0 = int'(addr_out); cnt = 0;
      for (int i = 0; i < 4 * CLK_DIV; i++) begin step(0, 3, 0, 15); cnt += int'(tick); end
      check("hold_addr", int'(addr_out), a0);
      check("hold_ticks", cnt, 4);

      // write the displayed entry; visible two cycles later
      step(0, 3, 0, 15, 1, a0, 4'b1010);
      step(0, 3, 0, 15);
      step(0, 3, 0, 15);
      v = (((m_n - 1) % 16) < 15) ? 4'b1010 : 0;
      check("wr_visible", int'(led), v);
      step(0, 3, 0, 15, 1, 9, 4'b1111);
      step(0, 3, 0, 15);
      step(0, 3, 0, 15);
      v = (((m_n - 1) % 16) < 15) ? 4'b1010 : 0;
      check("wr_oob_ignored", int'(led), v);

      // brightness 0: dark for 64 cycles
      cnt = 0;
      for (int i = 0; i < 64; i++) begin step(0, 3, 0, 0); cnt += int'(led != 0); end
      check("bright0_dark", cnt, 0);

      // brightness 4: on exactly 4 of 16 cycles
      step(0, 3, 0, 4); step(0, 3, 0, 4);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin step(0, 3, 0, 4); cnt += int'(led != 0); end
      check("bright4_duty", cnt, 4);

      // ping-pong from reset: triangle sequence, no repeats at the ends
      step(1, 2, 0, 15);
      for (int k = 1; k <= 20; k++) begin
         cnt = 0; seen = 0;
         while (!seen && cnt < 2 * CLK_DIV) begin
            a0 = int'(addr_out); step(0, 2, 0, 15); cnt++;
            seen = (int'(addr_out) != a0);
         end
         v = k % 14;
         check($sformatf("pp_step%0d", k), int'(addr_out), (v <= 7) ? v : 14 - v);
      end

      // reverse from addr 0 wraps to DEPTH-1
      step(1, 1, 0, 15);
      cnt = 0;
      while (addr_out == 0 && cnt < 2 * CLK_DIV) begin step(0, 1, 0, 15); cnt++; end
      check("rev_wrap", int'(addr_out), DEPTH - 1);

      // reset mid ping-pong at addr 5 heading down
      step(1, 2, 0, 15);
      cnt = 0;
      while (!(addr_out == 5 && !m_up) && cnt < 200) begin step(0, 2, 0, 15); cnt++; end
      check("reach_5_down", int'(addr_out == 5 && !m_up), 1);
      step(1, 2, 0, 15);
      check("rst_addr", int'(addr_out), 0);
      check("rst_led", int'(led), 0);
      check("rst_tick", int'(tick), 0);
      cnt = 0;
      while (!tick && cnt < 4 * CLK_DIV) begin step(0, 2, 0, 15); cnt++; end
      check("first_tick_cycle", cnt, CLK_DIV);
      step(0, 2, 0, 15);
      check("dir_up_after_rst", int'(addr_out), 1);

      // randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 15),
              ($urandom_range(0, 9) == 0), $urandom_range(0, 15), $urandom_range(0, 15));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
